// File: rtl/req_encoder_if.sv
// Handshake bundle between a request source/consumer and req_encoder.
// The block is the slave: it takes requests and ready, and returns codes and status.
interface req_encoder_if;
  logic [7:0] data_in;
  logic       load;
  logic       busy;
  logic [2:0] data_out;
  logic       out_valid;
  logic       out_ready;
  logic       done;
  logic [3:0] count;

  modport master (
    output data_in, load, out_ready,
    input  busy, data_out, out_valid, done, count
  );

  modport slave (
    input  data_in, load, out_ready,
    output busy, data_out, out_valid, done, count
  );
endinterface

// File: rtl/req_encoder.sv
// Sequential 8-to-3 priority encoder: serves the set bits of a captured request
// vector lowest-index first, one code per valid/ready handshake, then pulses done.
module req_encoder (
  input  logic          clk,
  input  logic          rst_n,
  req_encoder_if.slave  bus
);

  localparam int unsigned REQ_W  = 8;
  localparam int unsigned CODE_W = 3;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [REQ_W-1:0]   pending_q, pending_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               done_q, done_d;

  logic [CODE_W-1:0]  low_idx_c;
  logic [REQ_W-1:0]   low_bit_c;

  // Index of the lowest set pending bit; scanning downward lets bit 0 win.
  always_comb begin
    low_idx_c = '0;
    for (int i = int'(REQ_W) - 1; i >= 0; i--) begin
      if (pending_q[i]) low_idx_c = CODE_W'(i);
    end
  end

  // Two's-complement trick isolates the lowest set bit as a one-hot mask.
  assign low_bit_c = pending_q & (~pending_q + REQ_W'(1));

  // Next-state and register updates.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    count_d   = count_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          count_d = '0;
          if (bus.data_in != '0) begin
            pending_d = bus.data_in;
            state_d   = SERVE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      SERVE: begin
        if (bus.out_ready) begin
          pending_d = pending_q & ~low_bit_c;
          count_d   = count_q + CNT_W'(1);
          if (pending_d == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      count_q   <= count_d;
      done_q    <= done_d;
    end
  end

  // Status decodes straight from the state register; the code is forced to 0 outside SERVE.
  assign bus.busy      = (state_q == SERVE);
  assign bus.out_valid = (state_q == SERVE);
  assign bus.data_out  = (state_q == SERVE) ? low_idx_c : '0;
  assign bus.done      = done_q;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_req_encoder.sv
// Directed bench for req_encoder: a queue-based model of the expected code stream
// is compared against the DUT after every clock edge, plus literal spot checks.
module tb_req_encoder;

  logic clk;
  logic rst_n;

  req_encoder_if bus ();

  req_encoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: codes still owed for the current vector, accepted count, done flag.
  int q[$];
  int m_count;
  int m_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all();
    chk("busy",      32'(bus.busy),      32'(q.size() > 0));
    chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
    chk("data_out",  32'(bus.data_out),  (q.size() > 0) ? 32'(q[0]) : 32'd0);
    chk("count",     32'(bus.count),     32'(m_count));
    chk("done",      32'(bus.done),      32'(m_done));
  endtask

  // What the coming rising edge must do, given the inputs currently applied.
  task automatic model_edge();
    int dn;
    logic [7:0] v;
    dn = 0;
    if (q.size() > 0) begin
      if (bus.out_ready) begin
        void'(q.pop_front());
        m_count++;
        if (q.size() == 0) dn = 1;
      end
    end else if (bus.load) begin
      v = bus.data_in;
      q = {};
      for (int i = 0; i < 8; i++) if (v[i]) q.push_back(i);
      m_count = 0;
      if (q.size() == 0) dn = 1;
    end
    m_done = dn;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.data_in   = 8'h00;
    bus.load      = 1'b0;
    bus.out_ready = 1'b0;
    q = {};
    m_count = 0;
    m_done  = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("reset_count_lit", 32'(bus.count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single bit: code 5, then done with count 1.
    bus.data_in = 8'b0010_0000; bus.load = 1'b1; bus.out_ready = 1'b1;
    tick();
    chk("single_code_lit", 32'(bus.data_out), 32'd5);
    bus.load = 1'b0;
    tick();
    chk("single_done_lit",  32'(bus.done),  32'd1);
    chk("single_count_lit", 32'(bus.count), 32'd1);
    tick();
    chk("single_done_drop_lit", 32'(bus.done), 32'd0);

    // Full vector: codes 0..7 on consecutive cycles.
    bus.data_in = 8'hFF; bus.load = 1'b1;
    tick();
    chk("full_code0_lit", 32'(bus.data_out), 32'd0);
    bus.load = 1'b0;
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("full_code_lit", 32'(bus.data_out), 32'(i));
    end
    tick();
    chk("full_done_lit",  32'(bus.done),  32'd1);
    chk("full_count_lit", 32'(bus.count), 32'd8);
    tick();

    // Backpressure: code 1 holds for 3 stalled cycles, then 1, 7, done.
    bus.data_in = 8'b1000_0010; bus.load = 1'b1; bus.out_ready = 1'b0;
    tick();
    bus.load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_code_lit", 32'(bus.data_out), 32'd1);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp_code7_lit", 32'(bus.data_out), 32'd7);
    tick();
    chk("bp_done_lit",  32'(bus.done),  32'd1);
    chk("bp_count_lit", 32'(bus.count), 32'd2);
    tick();

    // Load while busy is ignored: only codes 2, 3.
    bus.data_in = 8'h0C; bus.load = 1'b1;
    tick();
    chk("busy_code2_lit", 32'(bus.data_out), 32'd2);
    bus.data_in = 8'h01;
    tick();
    chk("busy_code3_lit", 32'(bus.data_out), 32'd3);
    bus.load = 1'b0;
    tick();
    chk("busy_done_lit",  32'(bus.done),  32'd1);
    chk("busy_count_lit", 32'(bus.count), 32'd2);
    tick();

    // Empty vector: immediate done, never valid.
    bus.data_in = 8'h00; bus.load = 1'b1;
    tick();
    chk("empty_done_lit",  32'(bus.done),      32'd1);
    chk("empty_valid_lit", 32'(bus.out_valid), 32'd0);
    chk("empty_count_lit", 32'(bus.count),     32'd0);
    bus.load = 1'b0;
    tick();
    tick();

    // Abort: reset mid-cycle after 2 accepts of 8'hF0.
    bus.data_in = 8'hF0; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    tick();
    tick();
    chk("abort_pre_count_lit", 32'(bus.count), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    q = {};
    m_count = 0;
    m_done  = 0;
    check_all();
    chk("abort_data_lit", 32'(bus.data_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("abort_nodone_lit", 32'(bus.done), 32'd0);
    bus.data_in = 8'h01; bus.load = 1'b1;
    tick();
    chk("post_code_lit", 32'(bus.data_out), 32'd0);
    bus.load = 1'b0;
    tick();
    chk("post_done_lit",  32'(bus.done),  32'd1);
    chk("post_count_lit", 32'(bus.count), 32'd1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
